// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller, the IF/MEM stages and the byte-wide RAM.
interface mem_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              inst_req;
    logic [31:0]       inst_addr;
    logic              inst_valid;
    logic [31:0]       inst_valid_addr;
    logic [31:0]       inst_data;

    logic              data_req;
    logic              data_we;
    logic [31:0]       data_addr;
    logic [1:0]        data_size;
    logic [31:0]       data_wdata;
    logic              data_done;
    logic [31:0]       data_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    // Controller side
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_size, data_wdata,
        input  ram_din,
        output inst_valid, inst_valid_addr, inst_data,
        output data_done, data_rdata,
        output ram_addr, ram_wr, ram_dout
    );

    // Requester / RAM side
    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_size, data_wdata,
        output ram_din,
        input  inst_valid, inst_valid_addr, inst_data,
        input  data_done, data_rdata,
        input  ram_addr, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IF fetch misses against MEM loads/stores and
// serialises each access into byte cycles on a single synchronous RAM port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | sample requests; data_req has priority over inst_req
// READ  | cnt 0..n: present base+cnt while cnt<n, capture byte cnt-1 when cnt>=1
// WRITE | cnt 0..n-1: write wdata byte cnt to base+cnt
// DONE  | one-cycle completion pulse for the owning source
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input logic      clk,
    input logic      rst,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [31:0] base;
    logic [31:0] wdata;
    logic        src_inst;
    logic [31:0] rbuf;

    logic [2:0]        cnt_inc;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        wbyte_next;
    logic [31:0]       rbuf_next;
    logic [2:0]        data_n;

    // Next-address/byte helpers and read-byte assembly (little-endian)
    always_comb begin
        cnt_inc   = cnt + 3'd1;
        addr_next = base[ADDR_W-1:0] + {{(ADDR_W-3){1'b0}}, cnt_inc};
        case (cnt_inc[1:0])
            2'd0:    wbyte_next = wdata[7:0];
            2'd1:    wbyte_next = wdata[15:8];
            2'd2:    wbyte_next = wdata[23:16];
            default: wbyte_next = wdata[31:24];
        endcase
        rbuf_next = rbuf;
        if (state == READ) begin
            case (cnt)
                3'd1:    rbuf_next[7:0]   = bus.ram_din;
                3'd2:    rbuf_next[15:8]  = bus.ram_din;
                3'd3:    rbuf_next[23:16] = bus.ram_din;
                3'd4:    rbuf_next[31:24] = bus.ram_din;
                default: rbuf_next = rbuf;
            endcase
        end
        case (bus.data_size)
            2'd0:    data_n = 3'd1;
            2'd1:    data_n = 3'd2;
            default: data_n = 3'd4;
        endcase
    end

    // Sequencer with registered RAM and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            cnt                 <= '0;
            n_bytes             <= '0;
            base                <= '0;
            wdata               <= '0;
            src_inst            <= 1'b0;
            rbuf                <= '0;
            bus.ram_addr        <= '0;
            bus.ram_wr          <= 1'b0;
            bus.ram_dout        <= '0;
            bus.inst_valid      <= 1'b0;
            bus.inst_valid_addr <= '0;
            bus.inst_data       <= '0;
            bus.data_done       <= 1'b0;
            bus.data_rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    rbuf <= '0;
                    if (bus.data_req) begin
                        base         <= bus.data_addr;
                        wdata        <= bus.data_wdata;
                        n_bytes      <= data_n;
                        src_inst     <= 1'b0;
                        bus.ram_addr <= bus.data_addr[ADDR_W-1:0];
                        if (bus.data_we) begin
                            state        <= WRITE;
                            bus.ram_wr   <= 1'b1;
                            bus.ram_dout <= bus.data_wdata[7:0];
                        end else begin
                            state <= READ;
                        end
                    end else if (bus.inst_req) begin
                        base         <= bus.inst_addr;
                        n_bytes      <= 3'd4;
                        src_inst     <= 1'b1;
                        bus.ram_addr <= bus.inst_addr[ADDR_W-1:0];
                        state        <= READ;
                    end
                end
                READ: begin
                    rbuf <= rbuf_next;
                    if (cnt == n_bytes) begin
                        state        <= DONE;
                        bus.ram_addr <= '0;
                        if (src_inst) begin
                            bus.inst_valid      <= 1'b1;
                            bus.inst_data       <= rbuf_next;
                            bus.inst_valid_addr <= base;
                        end else begin
                            bus.data_done  <= 1'b1;
                            bus.data_rdata <= rbuf_next;
                        end
                    end else begin
                        cnt          <= cnt_inc;
                        bus.ram_addr <= (cnt_inc < n_bytes) ? addr_next : '0;
                    end
                end
                WRITE: begin
                    if (cnt_inc == n_bytes) begin
                        state         <= DONE;
                        bus.ram_wr    <= 1'b0;
                        bus.ram_addr  <= '0;
                        bus.ram_dout  <= '0;
                        bus.data_done <= 1'b1;
                    end else begin
                        cnt          <= cnt_inc;
                        bus.ram_addr <= addr_next;
                        bus.ram_dout <= wbyte_next;
                    end
                end
                default: begin
                    bus.inst_valid <= 1'b0;
                    bus.data_done  <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;

    localparam int ADDR_W = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic              tb_we = 1'b0;
    logic [ADDR_W-1:0] tb_waddr = '0;
    logic [7:0]        tb_wbyte = '0;

    mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // RAM model: read data one cycle after address, writes on posedge
    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wbyte;
        else if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_dout;
        bus.ram_din <= mem[bus.ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] b);
        tb_we = 1'b1; tb_waddr = a; tb_wbyte = b;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic quiet();
        bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0;
        bus.data_size = '0; bus.data_wdata = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        tick(); tick(); tick();
        n_vec++;
        if ({bus.ram_wr, bus.ram_addr, bus.ram_dout, bus.inst_valid, bus.data_done} !== '0) begin
            n_err++; $display("FAIL reset_ram_ctl got wr=%b addr=%h dout=%h iv=%b dd=%b exp all 0",
                bus.ram_wr, bus.ram_addr, bus.ram_dout, bus.inst_valid, bus.data_done);
        end
        n_vec++;
        if ({bus.inst_data, bus.inst_valid_addr, bus.data_rdata} !== 96'd0) begin
            n_err++; $display("FAIL reset_results got %h %h %h exp 0", bus.inst_data, bus.inst_valid_addr, bus.data_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        poke(17'h1000, 8'h13); poke(17'h1001, 8'h05); poke(17'h1002, 8'h00); poke(17'h1003, 8'h00);
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) bus.inst_req = 1'b0;
            if (k <= 4) begin
                n_vec++;
                if (bus.ram_addr !== 17'(32'h1000 + k - 1) || bus.ram_wr !== 1'b0) begin
                    n_err++; $display("FAIL fetch_addr k=%0d got %h wr=%b exp %h", k, bus.ram_addr, bus.ram_wr, 17'(32'h1000 + k - 1));
                end
            end
            n_vec++;
            if (bus.inst_valid !== (k == 6)) begin
                n_err++; $display("FAIL fetch_valid k=%0d got %b exp %b", k, bus.inst_valid, (k == 6));
            end
            if (k == 6) begin
                n_vec++;
                if (bus.inst_data !== 32'h00000513 || bus.inst_valid_addr !== 32'h1000) begin
                    n_err++; $display("FAIL fetch_data got %h @%h exp 00000513 @00001000", bus.inst_data, bus.inst_valid_addr);
                end
            end
        end
    endtask

    task automatic test_store_word();
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_size = 2'd2;
        bus.data_addr = 32'h20; bus.data_wdata = 32'hDEADBEEF;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) quiet();
            if (k <= 4) begin
                n_vec++;
                if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 17'(32'h20 + k - 1) || bus.ram_dout !== exp_b[k-1]) begin
                    n_err++; $display("FAIL store_cycle k=%0d got wr=%b %h=%h exp wr=1 %h=%h", k, bus.ram_wr,
                        bus.ram_addr, bus.ram_dout, 17'(32'h20 + k - 1), exp_b[k-1]);
                end
            end else begin
                n_vec++;
                if (bus.ram_wr !== 1'b0) begin
                    n_err++; $display("FAIL store_wr_off k=%0d got %b exp 0", k, bus.ram_wr);
                end
            end
            n_vec++;
            if (bus.data_done !== (k == 5)) begin
                n_err++; $display("FAIL store_done k=%0d got %b exp %b", k, bus.data_done, (k == 5));
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[17'h20 + 17'(i)] !== exp_b[i]) begin
                n_err++; $display("FAIL store_ram i=%0d got %h exp %h", i, mem[17'h20 + 17'(i)], exp_b[i]);
            end
        end
    endtask

    task automatic test_priority();
        poke(17'h40, 8'h80);
        poke(17'h0, 8'h67); poke(17'h1, 8'h45); poke(17'h2, 8'h23); poke(17'h3, 8'h01);
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_size = 2'd0; bus.data_addr = 32'h40;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) bus.data_req = 1'b0;
            if (k == 5) bus.inst_req = 1'b0;
            if (k == 1) begin
                n_vec++;
                if (bus.ram_addr !== 17'h40) begin
                    n_err++; $display("FAIL prio_first_addr got %h exp 00040", bus.ram_addr);
                end
            end
            n_vec++;
            if (bus.data_done !== (k == 3)) begin
                n_err++; $display("FAIL prio_done k=%0d got %b exp %b", k, bus.data_done, (k == 3));
            end
            if (k == 3) begin
                n_vec++;
                if (bus.data_rdata !== 32'h00000080) begin
                    n_err++; $display("FAIL prio_rdata got %h exp 00000080", bus.data_rdata);
                end
            end
            if (k == 5) begin
                n_vec++;
                if (bus.inst_data !== 32'h00000513) begin
                    n_err++; $display("FAIL prio_inst_hold got %h exp 00000513", bus.inst_data);
                end
            end
            if (k == 6) begin
                n_vec++;
                if (bus.ram_addr !== 17'h1) begin
                    n_err++; $display("FAIL prio_inst_start got %h exp 00001", bus.ram_addr);
                end
            end
            n_vec++;
            if (bus.inst_valid !== (k == 10)) begin
                n_err++; $display("FAIL prio_ivalid k=%0d got %b exp %b", k, bus.inst_valid, (k == 10));
            end
            if (k == 10) begin
                n_vec++;
                if (bus.inst_data !== 32'h01234567 || bus.inst_valid_addr !== 32'h0) begin
                    n_err++; $display("FAIL prio_idata got %h @%h exp 01234567 @00000000", bus.inst_data, bus.inst_valid_addr);
                end
            end
        end
    endtask

    task automatic test_wrap();
        poke(17'h1FFFF, 8'h34); poke(17'h0, 8'h12);
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_size = 2'd1; bus.data_addr = 32'h1FFFF;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) quiet();
            if (k == 1 || k == 2) begin
                n_vec++;
                if (bus.ram_addr !== ((k == 1) ? 17'h1FFFF : 17'h0)) begin
                    n_err++; $display("FAIL wrap_addr k=%0d got %h exp %h", k, bus.ram_addr, ((k == 1) ? 17'h1FFFF : 17'h0));
                end
            end
            n_vec++;
            if (bus.data_done !== (k == 4)) begin
                n_err++; $display("FAIL wrap_done k=%0d got %b exp %b", k, bus.data_done, (k == 4));
            end
            if (k == 4) begin
                n_vec++;
                if (bus.data_rdata !== 32'h00001234) begin
                    n_err++; $display("FAIL wrap_rdata got %h exp 00001234", bus.data_rdata);
                end
            end
        end
    endtask

    task automatic test_sizes();
        poke(17'h100, 8'h9A); poke(17'h103, 8'hBC);
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_size = 2'd1;
        bus.data_addr = 32'h101; bus.data_wdata = 32'h12345678;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) quiet();
            n_vec++;
            if (bus.data_done !== (k == 3)) begin
                n_err++; $display("FAIL half_store_done k=%0d got %b exp %b", k, bus.data_done, (k == 3));
            end
            if (k == 2) begin
                n_vec++;
                if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 17'h102 || bus.ram_dout !== 8'h56) begin
                    n_err++; $display("FAIL half_store_b1 got wr=%b %h=%h exp wr=1 00102=56", bus.ram_wr, bus.ram_addr, bus.ram_dout);
                end
            end
        end
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_size = 2'd3; bus.data_addr = 32'h100;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) quiet();
            n_vec++;
            if (bus.data_done !== (k == 6)) begin
                n_err++; $display("FAIL size3_done k=%0d got %b exp %b", k, bus.data_done, (k == 6));
            end
            if (k == 6) begin
                n_vec++;
                if (bus.data_rdata !== 32'hBC56789A) begin
                    n_err++; $display("FAIL size3_rdata got %h exp BC56789A", bus.data_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        poke(17'h80, 8'h11); poke(17'h81, 8'h22); poke(17'h82, 8'h33); poke(17'h83, 8'h44);
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_size = 2'd2;
        bus.data_addr = 32'h80; bus.data_wdata = 32'hA1B2C3D4;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) quiet();
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                rst = 1'b0;
                n_vec++;
                if ({bus.ram_wr, bus.ram_addr, bus.ram_dout, bus.inst_valid, bus.data_done} !== '0) begin
                    n_err++; $display("FAIL rstmid_ram got wr=%b addr=%h dout=%h exp 0", bus.ram_wr, bus.ram_addr, bus.ram_dout);
                end
                n_vec++;
                if ({bus.inst_data, bus.inst_valid_addr, bus.data_rdata} !== 96'd0) begin
                    n_err++; $display("FAIL rstmid_results got %h %h %h exp 0", bus.inst_data, bus.inst_valid_addr, bus.data_rdata);
                end
            end
            if (k >= 3) begin
                n_vec++;
                if (bus.data_done !== 1'b0 || bus.ram_wr !== 1'b0) begin
                    n_err++; $display("FAIL rstmid_quiet k=%0d got dd=%b wr=%b exp 0", k, bus.data_done, bus.ram_wr);
                end
            end
        end
        n_vec++;
        if ({mem[17'h80], mem[17'h81], mem[17'h82], mem[17'h83]} !== 32'hD4C33344) begin
            n_err++; $display("FAIL rstmid_ram_bytes got %h%h%h%h exp D4C33344", mem[17'h80], mem[17'h81], mem[17'h82], mem[17'h83]);
        end
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_size = 2'd2; bus.data_addr = 32'h80;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) quiet();
            n_vec++;
            if (bus.data_done !== (k == 6)) begin
                n_err++; $display("FAIL rstmid_load_done k=%0d got %b exp %b", k, bus.data_done, (k == 6));
            end
            if (k == 6) begin
                n_vec++;
                if (bus.data_rdata !== 32'h4433C3D4) begin
                    n_err++; $display("FAIL rstmid_load got %h exp 4433C3D4", bus.data_rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int starts = 0;
        poke(17'h200, 8'hAA); poke(17'h201, 8'hBB); poke(17'h202, 8'hCC); poke(17'h203, 8'hDD);
        bus.inst_req = 1'b1; bus.inst_addr = 32'h200;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 7) bus.inst_req = 1'b0;
            if (bus.inst_valid === 1'b1) pulses++;
            if (bus.ram_addr === 17'h200) starts++;
        end
        n_vec++;
        if (pulses != 1 || starts != 1) begin
            n_err++; $display("FAIL hold_single got pulses=%0d fetches=%0d exp 1 1", pulses, starts);
        end
        n_vec++;
        if (bus.inst_data !== 32'hDDCCBBAA || bus.inst_valid_addr !== 32'h200) begin
            n_err++; $display("FAIL hold_data got %h @%h exp DDCCBBAA @00000200", bus.inst_data, bus.inst_valid_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        test_reset();
        test_fetch();
        tick();
        test_store_word();
        tick();
        test_priority();
        tick();
        test_wrap();
        tick();
        test_sizes();
        tick();
        test_reset_mid();
        tick();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
